// File: rtl/tekito_program_memory.sv
// tekito_program_memory: instruction memory for the TEKITO fetch port.
// A byte array is read combinationally by the CPU and filled at run time
// through a nibble-wide valid/ready loader. While a load session is open,
// the CPU is held in reset; closing the session releases it to fetch from 0.
module tekito_program_memory #(
  parameter int ADDR_WIDTH     = 6,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] MEMORY_ADDR,
  output logic [7:0]            MEMORY_DATA,
  input  logic                  LOAD_START,
  input  logic                  LOAD_END,
  input  logic                  LOAD_VALID,
  input  logic [3:0]            LOAD_NIBBLE,
  output logic                  LOAD_READY,
  output logic [ADDR_WIDTH-1:0] LOAD_ADDR,
  output logic                  LOAD_WRAP,
  output logic [7:0]            CHECKSUM,
  output logic                  CPU_RESET
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD_HI = 2'd1,
    ST_LOAD_LO = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   load_addr_q, load_addr_d;
  logic                    load_wrap_q, load_wrap_d;
  logic [7:0]              checksum_q, checksum_d;
  logic [3:0]              hi_q, hi_d;
  logic [7:0]              mem_q [DEPTH];

  logic                    ready;
  logic                    accept;
  logic                    clear_all;
  logic                    wr_en;
  logic [7:0]              wr_data;

  // The loader is only ready while a session is open; a nibble offered in
  // the same cycle as LOAD_START is refused because the session restarts.
  assign ready  = (state_q != ST_RUN);
  assign accept = LOAD_VALID && ready && !LOAD_START;

  // Next-state and datapath decisions, LOAD_START first, then nibble
  // handling, then LOAD_END.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    load_wrap_d = load_wrap_q;
    checksum_d  = checksum_q;
    hi_d        = hi_q;
    clear_all   = 1'b0;
    wr_en       = 1'b0;
    wr_data     = {hi_q, LOAD_NIBBLE};

    if (LOAD_START) begin
      state_d     = ST_LOAD_HI;
      load_addr_d = '0;
      load_wrap_d = 1'b0;
      checksum_d  = '0;
      hi_d        = '0;
      clear_all   = CLEAR_ON_START;
    end else begin
      case (state_q)
        ST_LOAD_HI: begin
          // A high nibble arriving with LOAD_END cannot form a byte; drop it.
          if (LOAD_END) begin
            state_d = ST_RUN;
          end else if (accept) begin
            hi_d    = LOAD_NIBBLE;
            state_d = ST_LOAD_LO;
          end
        end
        ST_LOAD_LO: begin
          // A completing low nibble commits even when LOAD_END closes the session.
          if (accept) begin
            wr_en       = 1'b1;
            checksum_d  = checksum_q + wr_data;
            load_addr_d = load_addr_q + ADDR_WIDTH'(1);
            if (load_addr_q == {ADDR_WIDTH{1'b1}}) begin
              load_wrap_d = 1'b1;
            end
            state_d = LOAD_END ? ST_RUN : ST_LOAD_HI;
          end else if (LOAD_END) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Session control registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_RUN;
      load_addr_q <= '0;
      load_wrap_q <= 1'b0;
      checksum_q  <= '0;
      hi_q        <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      load_wrap_q <= load_wrap_d;
      checksum_q  <= checksum_d;
      hi_q        <= hi_d;
    end
  end

  // Program storage: cleared to NOP on reset and optionally on session start.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (clear_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_q[load_addr_q] <= wr_data;
    end
  end

  assign MEMORY_DATA = mem_q[MEMORY_ADDR];
  assign LOAD_READY  = ready;
  assign LOAD_ADDR   = load_addr_q;
  assign LOAD_WRAP   = load_wrap_q;
  assign CHECKSUM    = checksum_q;
  // Gating with RESET keeps the CPU in reset for as long as the block is.
  assign CPU_RESET   = RESET && (state_q == ST_RUN);

endmodule
